// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: instruction kind encoding,
// stall_cause bit positions and the per-kind result latency.
package hazard_pkg;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_MUL  = 2'b10,
    KIND_RSVD = 2'b11
  } kind_e;

  localparam int CAUSE_RAW    = 0;
  localparam int CAUSE_WAW    = 1;
  localparam int CAUSE_STRUCT = 2;

  // Reserved kind 11 behaves like an ALU op.
  function automatic int lat(input logic [1:0] kind, input int alu_lat,
                             input int load_lat, input int mul_lat);
    case (kind)
      KIND_LOAD: return load_lat;
      KIND_MUL:  return mul_lat;
      default:   return alu_lat;
    endcase
  endfunction

endpackage

// File: rtl/hz_cnt.sv
// Saturating down-counter with parallel load and hold, async cleared.
// One instance per register plus one tracking multiplier occupancy.
module hz_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  // Load wins over the decrement; en=0 freezes the counter entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (load)
        count <= load_val;
      else if (count != '0)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard detecting RAW, WAW
// and multiplier structural hazards, plus a saturating bubble statistic.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 4,
  parameter int EX_SLACK = 1,
  parameter int ZERO_REG = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_stall,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_kind,
  input  logic              stat_clr,
  output logic              ctrl_flush,
  output logic              pc_write,
  output logic              id_write,
  output logic [2:0]        stall_cause,
  output logic [STAT_W-1:0] stall_count
);

  localparam int NREG    = 2 ** REG_AW;
  localparam int MAX_AL  = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int MAX_LAT = (MAX_AL > MUL_LAT) ? MAX_AL : MUL_LAT;
  localparam int LW      = $clog2(MAX_LAT + 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [LW-1:0] cnt [NREG];
  logic [LW-1:0] mul_cnt;
  logic [2:0]    cause;
  logic          stall;
  logic          issue;
  int            need;
  int            kind_lat;
  logic          rs_hit;
  logic          rt_hit;

  assign need     = id_is_branch ? 0 : EX_SLACK;
  assign kind_lat = lat(id_kind, ALU_LAT, LOAD_LAT, MUL_LAT);

  // With ZERO_REG, r0 never carries a pending result, so it is never a source.
  assign rs_hit = id_use_rs && !(ZERO_REG != 0 && id_rs == '0) && (int'(cnt[id_rs]) > need);
  assign rt_hit = id_use_rt && !(ZERO_REG != 0 && id_rt == '0) && (int'(cnt[id_rt]) > need);

  always_comb begin
    cause               = '0;
    cause[CAUSE_RAW]    = id_valid && (rs_hit || rt_hit);
    cause[CAUSE_WAW]    = id_valid && id_wr_en && (int'(cnt[id_rd]) > kind_lat);
    cause[CAUSE_STRUCT] = id_valid && (id_kind == KIND_MUL) && (int'(mul_cnt) > 1);
  end

  assign stall = |cause;
  assign issue = id_valid && !stall && !ext_stall;

  // Outputs are forced to the free-running values while reset is asserted.
  assign stall_cause = rst_n ? cause : '0;
  assign ctrl_flush  = rst_n && stall && !ext_stall;
  assign pc_write    = !rst_n || !(stall || ext_stall);
  assign id_write    = pc_write;

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    logic ld;
    assign ld = issue && id_wr_en && (id_rd == REG_AW'(r)) && !(ZERO_REG != 0 && r == 0);
    hz_cnt #(.W(LW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (!ext_stall),
      .load     (ld),
      .load_val (LW'(kind_lat)),
      .count    (cnt[r])
    );
  end

  hz_cnt #(.W(LW)) u_mul_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!ext_stall),
    .load     (issue && (id_kind == KIND_MUL)),
    .load_val (LW'(MUL_LAT)),
    .count    (mul_cnt)
  );

  // stat_clr takes priority over a coincident flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stat_clr)
      stall_count <= '0;
    else if (ctrl_flush && stall_count != STAT_MAX)
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard sequences and random traffic,
// checked against a timestamp-based reference model through an expected queue.
module tb_hazard_scoreboard;

  localparam int W = 26;

  typedef struct packed {
    logic       valid;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       br;
    logic       wr;
    logic [2:0] rd;
    logic [1:0] kind;
  } ins_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        ext_stall = 0;
  logic        id_valid = 0;
  logic [2:0]  id_rs = 0, id_rt = 0, id_rd = 0;
  logic        id_use_rs = 0, id_use_rt = 0, id_is_branch = 0, id_wr_en = 0;
  logic [1:0]  id_kind = 0;
  logic        stat_clr = 0;
  logic        ctrl_flush, pc_write, id_write;
  logic [2:0]  stall_cause;
  logic [15:0] stall_count;
  logic        s_flush, s_pw, s_iw;
  logic [2:0]  s_cause;
  logic [3:0]  sat_count;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: absolute ready times on an "active cycle" clock that
  // only advances when the pipeline is not frozen.
  int now_t;
  int ready_at [8];
  int mul_free_at;
  int m_cnt16;
  int m_cnt4;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_kind(id_kind), .stat_clr(stat_clr), .ctrl_flush(ctrl_flush),
    .pc_write(pc_write), .id_write(id_write), .stall_cause(stall_cause),
    .stall_count(stall_count)
  );

  hazard_scoreboard #(.STAT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_kind(id_kind), .stat_clr(stat_clr), .ctrl_flush(s_flush),
    .pc_write(s_pw), .id_write(s_iw), .stall_cause(s_cause),
    .stall_count(sat_count)
  );

  function automatic int rem(input int r);
    return (ready_at[r] > now_t) ? ready_at[r] - now_t : 0;
  endfunction

  function automatic int kind_lat(input logic [1:0] k);
    return (k == 2'b01) ? 2 : (k == 2'b10) ? 4 : 1;
  endfunction

  function automatic ins_t mk(input logic [1:0] kind, input logic wr, input int rd,
                              input logic use_rs, input int rs, input logic br);
    ins_t i;
    i.valid = 1; i.kind = kind; i.wr = wr; i.rd = 3'(rd);
    i.use_rs = use_rs; i.rs = 3'(rs); i.use_rt = 0; i.rt = 0; i.br = br;
    return i;
  endfunction

  task automatic model_clear();
    now_t = 0;
    for (int r = 0; r < 8; r++) ready_at[r] = 0;
    mul_free_at = 0;
    m_cnt16 = 0;
    m_cnt4 = 0;
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst_n = 0;
      model_clear();
      exp_q.push_back({1'b0, 1'b1, 1'b1, 3'b000, 16'd0, 4'd0});
    end
  endtask

  // Drives one ID cycle, pushes the predicted outputs and advances the model.
  task automatic step(input ins_t ins, input logic ext, input logic clr,
                      output logic act_flush, output logic act_pw);
    int nd;
    logic raw, waw, str, stl, fl, pw, iss;
    @(negedge clk);
    rst_n = 1;
    ext_stall = ext; stat_clr = clr;
    id_valid = ins.valid; id_rs = ins.rs; id_rt = ins.rt;
    id_use_rs = ins.use_rs; id_use_rt = ins.use_rt; id_is_branch = ins.br;
    id_wr_en = ins.wr; id_rd = ins.rd; id_kind = ins.kind;

    nd  = ins.br ? 0 : 1;
    raw = ins.valid && ((ins.use_rs && ins.rs != 0 && rem(ins.rs) > nd) ||
                        (ins.use_rt && ins.rt != 0 && rem(ins.rt) > nd));
    waw = ins.valid && ins.wr && rem(ins.rd) > kind_lat(ins.kind);
    str = ins.valid && ins.kind == 2'b10 && (mul_free_at - now_t) > 1;
    stl = raw | waw | str;
    fl  = stl & ~ext;
    pw  = ~(stl | ext);
    iss = ins.valid & ~stl & ~ext;
    exp_q.push_back({fl, pw, pw, str, waw, raw, 16'(m_cnt16), 4'(m_cnt4)});

    if (clr) begin
      m_cnt16 = 0; m_cnt4 = 0;
    end else if (fl) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (!ext) begin
      if (iss && ins.wr && ins.rd != 0) ready_at[ins.rd] = now_t + 1 + kind_lat(ins.kind);
      if (iss && ins.kind == 2'b10) mul_free_at = now_t + 1 + 4;
      now_t++;
    end
    #2;
    act_flush = ctrl_flush;
    act_pw = pc_write;
  endtask

  task automatic nops(input int n);
    logic f, p;
    ins_t z;
    z = '0;
    for (int i = 0; i < n; i++) step(z, 0, 0, f, p);
  endtask

  // Holds the consumer in ID until the DUT lets it issue, counting bubbles.
  task automatic run_consumer(input ins_t ins, input int exp_b, input string name);
    int b;
    logic done, f, p;
    b = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      step(ins, 0, 0, f, p);
      if (f) b++;
      if (p) done = 1;
    end
    checks++;
    if (!done || b != exp_b) begin
      errors++;
      $display("FAIL %s: bubbles=%0d issued=%0d, required bubbles=%0d issued=1",
               name, b, done, exp_b);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {ctrl_flush, pc_write, id_write, stall_cause, stall_count, sat_count};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs @%0t: got flush=%b pcw=%b idw=%b cause=%b cnt=%0d sat=%0d, required flush=%b pcw=%b idw=%b cause=%b cnt=%0d sat=%0d",
                   $time, act_v[25], act_v[24], act_v[23], act_v[22:20], act_v[19:4], act_v[3:0],
                   exp_v[25], exp_v[24], exp_v[23], exp_v[22:20], exp_v[19:4], exp_v[3:0]);
        end
      end
    end
  end

  initial begin : driver
    logic f, p;
    ins_t ins;
    model_clear();
    do_reset(2);

    step(mk(2'b01, 1, 3, 0, 0, 0), 0, 0, f, p);
    run_consumer(mk(2'b00, 1, 4, 1, 3, 0), 1, "load_use");
    nops(5);
    step(mk(2'b00, 1, 2, 0, 0, 0), 0, 0, f, p);
    run_consumer(mk(2'b00, 0, 0, 1, 2, 1), 1, "alu_branch");
    nops(5);
    step(mk(2'b01, 1, 2, 0, 0, 0), 0, 0, f, p);
    run_consumer(mk(2'b00, 0, 0, 1, 2, 1), 2, "load_branch");
    nops(5);
    step(mk(2'b00, 1, 2, 0, 0, 0), 0, 0, f, p);
    run_consumer(mk(2'b00, 1, 6, 1, 2, 0), 0, "alu_alu");
    nops(5);
    step(mk(2'b10, 1, 5, 0, 0, 0), 0, 0, f, p);
    nops(1);
    run_consumer(mk(2'b00, 1, 5, 0, 0, 0), 2, "mul_waw");
    nops(5);
    step(mk(2'b10, 1, 1, 0, 0, 0), 0, 0, f, p);
    run_consumer(mk(2'b10, 1, 2, 0, 0, 0), 3, "mul_struct");
    nops(5);
    step(mk(2'b01, 1, 3, 0, 0, 0), 0, 0, f, p);
    for (int i = 0; i < 5; i++) step(mk(2'b00, 1, 4, 1, 3, 0), 1, 0, f, p);
    run_consumer(mk(2'b00, 1, 4, 1, 3, 0), 1, "ext_release");
    nops(5);
    step(mk(2'b01, 1, 0, 0, 0, 0), 0, 0, f, p);
    run_consumer(mk(2'b00, 1, 1, 1, 0, 1), 0, "zero_reg");
    step(mk(2'b10, 1, 6, 0, 0, 0), 0, 0, f, p);
    do_reset(1);
    run_consumer(mk(2'b00, 0, 0, 1, 6, 1), 0, "reset_mid_mul");
    step(mk(2'b00, 0, 0, 0, 0, 0), 0, 1, f, p);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(2);
      end else begin
        ins.valid  = ($urandom_range(0, 9) != 0);
        ins.rs     = 3'($urandom_range(0, 7));
        ins.rt     = 3'($urandom_range(0, 7));
        ins.use_rs = 1'($urandom_range(0, 1));
        ins.use_rt = 1'($urandom_range(0, 1));
        ins.br     = ($urandom_range(0, 3) == 0);
        ins.wr     = ($urandom_range(0, 3) != 0);
        ins.rd     = 3'($urandom_range(0, 7));
        ins.kind   = 2'($urandom_range(0, 3));
        step(ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0), f, p);
      end
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
